// File: rtl/axo_csr_file.sv
// Machine-mode CSR storage for the RV32 core: holds the CSR state, serves
// combinational reads and legality, and applies trap entry / MRET updates.
module axo_csr_file #(
    parameter logic [31:0] MISA_VAL = 32'h40001100,
    parameter logic [31:0] HARTID   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  privilege,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic        csr_illegal,
    input  logic        retire,
    input  logic        irq_meip,
    input  logic        irq_mtip,
    input  logic        irq_msip,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic [31:0] trap_vector,
    output logic [31:0] epc,
    output logic        irq_pending
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    logic        mst_mie_q,  mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [1:0]  mst_mpp_q,  mst_mpp_d;
    logic [31:0] mie_q,      mie_d;
    logic [29:0] mtvec_base_q, mtvec_base_d;
    logic        mtvec_mode_q, mtvec_mode_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] mip_val;
    logic [31:0] tvec_base;
    logic        implemented;
    logic [31:0] rdata_raw;
    logic        wr_en;
    logic        unused_bits;

    assign unused_bits = ^{trap_cause[30], trap_pc[0]};

    assign mip_val   = {20'b0, irq_meip, 3'b0, irq_mtip, 3'b0, irq_msip, 3'b0};
    assign tvec_base = {mtvec_base_q, 2'b00};

    always_comb begin
        implemented = 1'b1;
        rdata_raw   = '0;
        case (csr_addr)
            A_MSTATUS:   rdata_raw = {19'b0, mst_mpp_q, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            A_MISA:      rdata_raw = MISA_VAL;
            A_MIE:       rdata_raw = mie_q;
            A_MTVEC:     rdata_raw = {mtvec_base_q, 1'b0, mtvec_mode_q};
            A_MSCRATCH:  rdata_raw = mscratch_q;
            A_MEPC:      rdata_raw = mepc_q;
            A_MCAUSE:    rdata_raw = mcause_q;
            A_MTVAL:     rdata_raw = mtval_q;
            A_MIP:       rdata_raw = mip_val;
            A_MCYCLE,   A_CYCLE:    rdata_raw = mcycle_q[31:0];
            A_MCYCLEH,  A_CYCLEH:   rdata_raw = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:  rdata_raw = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH: rdata_raw = minstret_q[63:32];
            A_MHARTID:   rdata_raw = HARTID;
            default:     implemented = 1'b0;
        endcase
    end

    assign csr_illegal = ~implemented
                       | (privilege < csr_addr[9:8])
                       | (csr_we & (csr_addr[11:10] == 2'b11));
    assign csr_rdata   = csr_illegal ? '0 : rdata_raw;

    // Trap and MRET both pre-empt a software write in the same cycle.
    assign wr_en = csr_we & ~csr_illegal & ~trap_valid & ~mret;

    always_comb begin
        mst_mie_d    = mst_mie_q;
        mst_mpie_d   = mst_mpie_q;
        mst_mpp_d    = mst_mpp_q;
        mie_d        = mie_q;
        mtvec_base_d = mtvec_base_q;
        mtvec_mode_d = mtvec_mode_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        mcycle_d     = mcycle_q + 64'd1;
        minstret_d   = retire ? minstret_q + 64'd1 : minstret_q;

        if (trap_valid) begin
            mepc_d     = {trap_pc[31:1], 1'b0};
            mcause_d   = trap_cause;
            mtval_d    = trap_tval;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mst_mpp_d  = privilege;
        end else if (mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            mst_mpp_d  = 2'b11;
        end else if (wr_en) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mst_mie_d  = csr_wdata[3];
                    mst_mpie_d = csr_wdata[7];
                    mst_mpp_d  = 2'b11;
                end
                A_MIE:       mie_d        = csr_wdata & MIE_MASK;
                A_MTVEC: begin
                    mtvec_base_d = csr_wdata[31:2];
                    mtvec_mode_d = (csr_wdata[1:0] == 2'b01);
                end
                A_MSCRATCH:  mscratch_d   = csr_wdata;
                A_MEPC:      mepc_d       = {csr_wdata[31:1], 1'b0};
                A_MCAUSE:    mcause_d     = csr_wdata;
                A_MTVAL:     mtval_d      = csr_wdata;
                A_MCYCLE:    mcycle_d     = {mcycle_q[63:32], csr_wdata};
                A_MCYCLEH:   mcycle_d     = {csr_wdata, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d   = {minstret_q[63:32], csr_wdata};
                A_MINSTRETH: minstret_d   = {csr_wdata, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie_q    <= 1'b0;
            mst_mpie_q   <= 1'b0;
            mst_mpp_q    <= 2'b11;
            mie_q        <= '0;
            mtvec_base_q <= '0;
            mtvec_mode_q <= 1'b0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
        end else begin
            mst_mie_q    <= mst_mie_d;
            mst_mpie_q   <= mst_mpie_d;
            mst_mpp_q    <= mst_mpp_d;
            mie_q        <= mie_d;
            mtvec_base_q <= mtvec_base_d;
            mtvec_mode_q <= mtvec_mode_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
        end
    end

    // Vectored mode only offsets interrupts; 4*cause wraps within 32 bits.
    assign trap_vector = (mtvec_mode_q && trap_cause[31])
                       ? tvec_base + {trap_cause[29:0], 2'b00}
                       : tvec_base;
    assign epc         = mepc_q;
    assign irq_pending = mst_mie_q & |(mie_q & mip_val);

endmodule

// File: tb/tb_axo_csr_file.sv
// Directed-vector bench for axo_csr_file; each task checks its own expectations.
module tb_axo_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  privilege;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        csr_illegal;
    logic        retire;
    logic        irq_meip, irq_mtip, irq_msip;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret;
    logic [31:0] trap_vector, epc;
    logic        irq_pending;

    int passed = 0;
    int total  = 0;

    axo_csr_file #(.MISA_VAL(32'h40001100), .HARTID(32'd0)) dut (
        .clk(clk), .rst(rst), .privilege(privilege), .csr_addr(csr_addr),
        .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .csr_illegal(csr_illegal), .retire(retire), .irq_meip(irq_meip),
        .irq_mtip(irq_mtip), .irq_msip(irq_msip), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret(mret), .trap_vector(trap_vector), .epc(epc), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_wdata = d; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 32'hFF;
        trap_valid = 1'b1; trap_pc = 32'h100; trap_cause = 32'h5;
        tick(); tick();
        csr_we = 1'b0; trap_valid = 1'b0; trap_cause = 32'h0;
        rd(12'hB00);
        total++; if (csr_rdata !== 32'h0) $display("FAIL rst_mcycle got=%h exp=%h", csr_rdata, 32'h0); else passed++;
        total++; if (irq_pending !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq_pending); else passed++;
        total++; if (trap_vector !== 32'h0) $display("FAIL rst_tvec got=%h exp=%h", trap_vector, 32'h0); else passed++;
        total++; if (epc !== 32'h0) $display("FAIL rst_epc got=%h exp=%h", epc, 32'h0); else passed++;
        rd(12'h300);
        total++; if (csr_rdata !== 32'h1800) $display("FAIL rst_mstatus got=%h exp=%h", csr_rdata, 32'h1800); else passed++;
        rd(12'h340);
        total++; if (csr_rdata !== 32'h0) $display("FAIL rst_mscratch got=%h exp=%h", csr_rdata, 32'h0); else passed++;
        rd(12'h342);
        total++; if (csr_rdata !== 32'h0) $display("FAIL rst_mcause got=%h exp=%h", csr_rdata, 32'h0); else passed++;
        rst = 1'b0;
        csr_addr = 12'hB00;
        tick();
        total++; if (csr_rdata !== 32'h1) $display("FAIL mcycle_first got=%h exp=%h", csr_rdata, 32'h1); else passed++;
    endtask

    task automatic test_readonly();
        rd(12'hF14);
        total++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) $display("FAIL mhartid got=%h/%b exp=0/0", csr_rdata, csr_illegal); else passed++;
        rd(12'h7C0);
        total++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) $display("FAIL unimpl got=%b/%h exp=1/0", csr_illegal, csr_rdata); else passed++;
        wr(12'h301, 32'h0);
        rd(12'h301);
        total++; if (csr_rdata !== 32'h40001100) $display("FAIL misa got=%h exp=%h", csr_rdata, 32'h40001100); else passed++;
        csr_addr = 12'hF14; csr_we = 1'b1; #1;
        total++; if (csr_illegal !== 1'b1) $display("FAIL hartid_wr got=%b exp=1", csr_illegal); else passed++;
        csr_we = 1'b0;
    endtask

    task automatic test_mtvec();
        wr(12'h305, 32'h80000103);
        rd(12'h305);
        total++; if (csr_rdata !== 32'h80000100) $display("FAIL mtvec_m3 got=%h exp=%h", csr_rdata, 32'h80000100); else passed++;
        wr(12'h305, 32'h80000101);
        rd(12'h305);
        total++; if (csr_rdata !== 32'h80000101) $display("FAIL mtvec_m1 got=%h exp=%h", csr_rdata, 32'h80000101); else passed++;
        trap_cause = 32'h80000007; #1;
        total++; if (trap_vector !== 32'h8000011C) $display("FAIL tvec_irq got=%h exp=%h", trap_vector, 32'h8000011C); else passed++;
        trap_cause = 32'h00000002; #1;
        total++; if (trap_vector !== 32'h80000100) $display("FAIL tvec_exc got=%h exp=%h", trap_vector, 32'h80000100); else passed++;
        wr(12'h305, 32'h80000102);
        rd(12'h305);
        total++; if (csr_rdata !== 32'h80000100) $display("FAIL mtvec_m2 got=%h exp=%h", csr_rdata, 32'h80000100); else passed++;
        trap_cause = 32'h80000007; #1;
        total++; if (trap_vector !== 32'h80000100) $display("FAIL tvec_direct got=%h exp=%h", trap_vector, 32'h80000100); else passed++;
        trap_cause = 32'h0;
    endtask

    task automatic test_irq_trap();
        irq_mtip = 1'b1;
        wr(12'h300, 32'h8);
        wr(12'h304, 32'hFFFFFFFF);
        rd(12'h304);
        total++; if (csr_rdata !== 32'h888) $display("FAIL mie_mask got=%h exp=%h", csr_rdata, 32'h888); else passed++;
        rd(12'h344);
        total++; if (csr_rdata !== 32'h80) $display("FAIL mip got=%h exp=%h", csr_rdata, 32'h80); else passed++;
        total++; if (irq_pending !== 1'b1) $display("FAIL irq_on got=%b exp=1", irq_pending); else passed++;
        trap_valid = 1'b1; trap_pc = 32'h1235; trap_cause = 32'h80000007; trap_tval = 32'hDEAD;
        tick();
        trap_valid = 1'b0;
        total++; if (epc !== 32'h1234) $display("FAIL trap_epc got=%h exp=%h", epc, 32'h1234); else passed++;
        rd(12'h342);
        total++; if (csr_rdata !== 32'h80000007) $display("FAIL trap_mcause got=%h exp=%h", csr_rdata, 32'h80000007); else passed++;
        rd(12'h343);
        total++; if (csr_rdata !== 32'hDEAD) $display("FAIL trap_mtval got=%h exp=%h", csr_rdata, 32'hDEAD); else passed++;
        rd(12'h300);
        total++; if (csr_rdata !== 32'h1880) $display("FAIL trap_mstatus got=%h exp=%h", csr_rdata, 32'h1880); else passed++;
        total++; if (irq_pending !== 1'b0) $display("FAIL trap_irq got=%b exp=0", irq_pending); else passed++;
        mret = 1'b1; tick(); mret = 1'b0;
        rd(12'h300);
        total++; if (csr_rdata !== 32'h1888) $display("FAIL mret_mstatus got=%h exp=%h", csr_rdata, 32'h1888); else passed++;
        total++; if (irq_pending !== 1'b1) $display("FAIL mret_irq got=%b exp=1", irq_pending); else passed++;
        irq_mtip = 1'b0; #1;
        total++; if (irq_pending !== 1'b0) $display("FAIL irq_off got=%b exp=0", irq_pending); else passed++;
    endtask

    task automatic test_counters();
        wr(12'hB00, 32'hFFFFFFFE);
        wr(12'hB80, 32'h0);
        rd(12'hB00);
        total++; if (csr_rdata !== 32'hFFFFFFFE) $display("FAIL mcycle_wr got=%h exp=%h", csr_rdata, 32'hFFFFFFFE); else passed++;
        tick(); tick();
        rd(12'hB80);
        total++; if (csr_rdata !== 32'h1) $display("FAIL mcycleh_carry got=%h exp=%h", csr_rdata, 32'h1); else passed++;
        rd(12'hB00);
        total++; if (csr_rdata !== 32'h0) $display("FAIL mcycle_wrap got=%h exp=%h", csr_rdata, 32'h0); else passed++;
        rd(12'hC80);
        total++; if (csr_rdata !== 32'h1) $display("FAIL cycleh got=%h exp=%h", csr_rdata, 32'h1); else passed++;
        csr_addr = 12'hC00; csr_wdata = 32'h55; csr_we = 1'b1; #1;
        total++; if (csr_illegal !== 1'b1) $display("FAIL cycle_wr_illegal got=%b exp=1", csr_illegal); else passed++;
        tick(); csr_we = 1'b0; #1;
        total++; if (csr_rdata !== 32'h1 || csr_illegal !== 1'b0) $display("FAIL cycle_after got=%h/%b exp=1/0", csr_rdata, csr_illegal); else passed++;
        wr(12'hB02, 32'h0);
        retire = 1'b1;
        tick(); tick(); tick();
        wr(12'hB82, 32'h7);
        retire = 1'b0;
        rd(12'hB02);
        total++; if (csr_rdata !== 32'h3) $display("FAIL minstret got=%h exp=%h", csr_rdata, 32'h3); else passed++;
        rd(12'hC82);
        total++; if (csr_rdata !== 32'h7) $display("FAIL instreth got=%h exp=%h", csr_rdata, 32'h7); else passed++;
    endtask

    task automatic test_priority();
        wr(12'h340, 32'hA);
        trap_valid = 1'b1; mret = 1'b1;
        trap_pc = 32'h2000; trap_cause = 32'hB; trap_tval = 32'h0;
        wr(12'h340, 32'h5);
        trap_valid = 1'b0; mret = 1'b0;
        rd(12'h340);
        total++; if (csr_rdata !== 32'hA) $display("FAIL prio_mscratch got=%h exp=%h", csr_rdata, 32'hA); else passed++;
        total++; if (epc !== 32'h2000) $display("FAIL prio_epc got=%h exp=%h", epc, 32'h2000); else passed++;
        rd(12'h300);
        total++; if (csr_rdata !== 32'h1880) $display("FAIL prio_mstatus got=%h exp=%h", csr_rdata, 32'h1880); else passed++;
        mret = 1'b1;
        wr(12'h300, 32'h0);
        mret = 1'b0;
        rd(12'h300);
        total++; if (csr_rdata !== 32'h1888) $display("FAIL mret_over_wr got=%h exp=%h", csr_rdata, 32'h1888); else passed++;
        privilege = 2'b00; trap_valid = 1'b1;
        tick();
        trap_valid = 1'b0; privilege = 2'b11;
        rd(12'h300);
        total++; if (csr_rdata !== 32'h0080) $display("FAIL trap_mpp_u got=%h exp=%h", csr_rdata, 32'h0080); else passed++;
    endtask

    task automatic test_privilege();
        privilege = 2'b00;
        rd(12'h341);
        total++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) $display("FAIL priv_u got=%b/%h exp=1/0", csr_illegal, csr_rdata); else passed++;
        wr(12'h340, 32'h77);
        privilege = 2'b01;
        rd(12'hC00);
        total++; if (csr_illegal !== 1'b0) $display("FAIL priv_s_cycle got=%b exp=0", csr_illegal); else passed++;
        privilege = 2'b11;
        rd(12'h341);
        total++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h2000) $display("FAIL priv_m got=%b/%h exp=0/2000", csr_illegal, csr_rdata); else passed++;
        rd(12'h340);
        total++; if (csr_rdata !== 32'hA) $display("FAIL illegal_wr got=%h exp=%h", csr_rdata, 32'hA); else passed++;
        wr(12'h341, 32'h12345677);
        rd(12'h341);
        total++; if (csr_rdata !== 32'h12345676) $display("FAIL mepc_wr got=%h exp=%h", csr_rdata, 32'h12345676); else passed++;
        total++; if (epc !== 32'h12345676) $display("FAIL epc_out got=%h exp=%h", epc, 32'h12345676); else passed++;
    endtask

    initial begin
        rst = 1'b1; privilege = 2'b11; csr_addr = '0; csr_we = 1'b0; csr_wdata = '0;
        retire = 1'b0; irq_meip = 1'b0; irq_mtip = 1'b0; irq_msip = 1'b0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret = 1'b0;
        test_reset();
        test_readonly();
        test_mtvec();
        test_irq_trap();
        test_counters();
        test_priority();
        test_privilege();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
